whack_a_mole_core_n: RTL and testbench
======================================

Name: whack_a_mole_core_n

Overview:
- Parametrised game engine for the next-generation whack-a-mole TinyTapeout design.
- Generalises the fixed 8-button game to N_MOLES channels.
- Adds level progression, a shrinking reaction window, a miss limit with game-over, and de-duplicated pseudo-random mole selection.
- Sits between the ui_in button pins and the display/score encoders inside the top-level tt_um wrapper.

Parameters:
N_MOLES, 8, number of buttons/moles (2..8)
SCORE_W, 8, score counter width
WIN_W, 16, reaction/gap timer width
WIN_INIT, 50000, reaction window in cycles at level 0
WIN_STEP, 5000, window reduction per level
WIN_MIN, 5000, minimum reaction window
GAP_CYCLES, 10000, dark time between moles
LEVEL_UP, 8, hits needed per level increment
MAX_MISS, 3, misses that end the game (1..15)
LFSR_SEED, 16'hACE1, LFSR reset value, must be nonzero

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous and active-low
start  in  1  synchronous start/restart request, level-sampled
btn  in  N_MOLES  raw active-high buttons, asynchronous
mole  out  N_MOLES  one-hot active mole, 0 when none
score  out  SCORE_W  hit count, saturating
level  out  4  current level, saturating at 15
misses  out  4  miss count
state  out  2  0=IDLE 1=GAP 2=UP 3=OVER
game_over  out  1  high while in OVER
hit_pulse  out  1  one-cycle pulse per hit
miss_pulse  out  1  one-cycle pulse per miss

Behaviour:
- Reset, asynchronous: state=IDLE; mole, score, level, misses, pulses, internal hit count and timer all 0; LFSR=LFSR_SEED; synchroniser flops 0. Reset mid-game aborts immediately and all outputs show reset values.
- Buttons:
  - Each bit passes through a 2-FF synchroniser (btn_s), then a delay flop (btn_d); rise = btn_s & ~btn_d.
  - A press set up before edge k is acted on at edge k+2.
  - Held buttons produce only one rise.
- LFSR: 16-bit Galois, mask 16'hB400, shifts every cycle in every state. Candidate index = lfsr[7:0] % N_MOLES.
- Timer: loaded with V-1 on state entry, decrements each cycle, expires when it reaches 0. A state timed by V therefore lasts exactly V cycles.
- IDLE: mole=0. On start: clear score, misses, level and hit count; load GAP_CYCLES; go to GAP.
- GAP: mole=0. On expiry:
  - choose index = candidate, or (candidate+1) % N_MOLES if candidate equals the previous mole index (previous = 0 after reset/start);
  - set mole one-hot; load the current window; go to UP.
- UP, evaluated each cycle, in priority order:
  - (1) Rise on the active button = hit:
    - score+1, saturating at all-ones; hit_pulse=1; hit count+1.
    - If hit count reaches LEVEL_UP: level+1 (saturating at 15), hit count=0.
    - mole=0; load GAP_CYCLES; go to GAP.
    - A hit wins over a simultaneous wrong press and over simultaneous timer expiry.
  - (2) Rise on any other button, or timer expiry = miss:
    - misses+1; miss_pulse=1; mole=0.
    - If misses reaches MAX_MISS: go to OVER. Otherwise load GAP_CYCLES and go to GAP.
- OVER: game_over=1, mole=0, score/level/misses held. start behaves exactly as in IDLE.
- start is ignored in GAP and UP.
- Pulses are registered, high for exactly the one cycle after the deciding edge.

Optional Feature:
- Macro: WAM_SPEEDUP_EN.
- Defined: window = max(WIN_INIT - level*WIN_STEP, WIN_MIN), computed without underflow (clamp before subtracting).
- Undefined: window = WIN_INIT at every level. Level still counts and is output.

Test Plan:
Bench parameters: N_MOLES=4, WIN_INIT=20, WIN_STEP=4, WIN_MIN=8, GAP_CYCLES=5, LEVEL_UP=2, MAX_MISS=3.
1. Reset, then 1 start cycle -> state=1 for exactly 5 cycles, then state=2 with mole one-hot (popcount 1) and score=0.
2. Press the active mole's button 3 cycles into UP -> hit_pulse once, score=1, mole=0, state=1. Holding the button through the next UP produces no second hit.
3. Score two hits -> level=1. With WAM_SPEEDUP_EN, the next UP lasts 16 cycles; without it, 20. At level 3 and above the window is 8 when WAM_SPEEDUP_EN is defined.
4. Idle through 3 windows -> miss_pulse three times, misses=3, state=3, game_over=1. start -> score=0, misses=0, state=1.
5. Press a wrong button and the correct button on the same cycle -> hit only. Press a wrong button alone -> miss. Correct press on the expiry cycle -> hit.
6. Assert rst_n=0 mid-UP -> mole=0, score=0, state=0 immediately without a clock edge. Over 200 moles, no two consecutive moles share an index.

Source files
------------

// File: rtl/whack_a_mole_core_n.sv
// Whack-a-mole game engine: N_MOLES buttons, level progression, miss limit, de-duplicated LFSR mole choice.
// Optional macro WAM_SPEEDUP_EN shrinks the reaction window as the level rises.
module whack_a_mole_core_n #(
    parameter int          N_MOLES    = 8,
    parameter int          SCORE_W    = 8,
    parameter int          WIN_W      = 16,
    parameter int          WIN_INIT   = 50000,
    parameter int          WIN_STEP   = 5000,
    parameter int          WIN_MIN    = 5000,
    parameter int          GAP_CYCLES = 10000,
    parameter int          LEVEL_UP   = 8,
    parameter int          MAX_MISS   = 3,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic [N_MOLES-1:0] btn_i,
    output logic [N_MOLES-1:0] mole_o,
    output logic [SCORE_W-1:0] score_o,
    output logic [3:0]         level_o,
    output logic [3:0]         misses_o,
    output logic [1:0]         state_o,
    output logic               game_over_o,
    output logic               hit_pulse_o,
    output logic               miss_pulse_o
);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_GAP = 2'd1, S_UP = 2'd2, S_OVER = 2'd3} state_t;

    localparam int IDX_W = (N_MOLES > 1) ? $clog2(N_MOLES) : 1;
    localparam int HC_W  = $clog2(LEVEL_UP + 1);

    state_t             state_q, state_d;
    logic [WIN_W-1:0]   timer_q, timer_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic [N_MOLES-1:0] btn_meta_q, btn_s_q, btn_d_q;
    logic [N_MOLES-1:0] mole_q, mole_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [3:0]         level_q, level_d;
    logic [3:0]         misses_q, misses_d;
    logic [HC_W-1:0]    hit_cnt_q, hit_cnt_d;
    logic [IDX_W-1:0]   prev_idx_q, prev_idx_d;
    logic               hit_pulse_q, hit_pulse_d;
    logic               miss_pulse_q, miss_pulse_d;

    logic [N_MOLES-1:0] rise;
    logic [IDX_W-1:0]   cand_idx, next_idx;
    logic [N_MOLES-1:0] mole_next;
    logic [WIN_W-1:0]   window;
    logic               hit, wrong, expired;

    assign rise     = btn_s_q & ~btn_d_q;
    assign cand_idx = IDX_W'(lfsr_q[7:0] % 8'(N_MOLES));
    // Never show the same mole twice in a row: bump a repeated candidate to its neighbour.
    assign next_idx = (cand_idx != prev_idx_q) ? cand_idx :
                      (cand_idx == IDX_W'(N_MOLES - 1)) ? '0 : cand_idx + 1'b1;
    assign hit      = |(rise & mole_q);
    assign wrong    = |(rise & ~mole_q);
    assign expired  = (timer_q == '0);

    always_comb begin
        mole_next           = '0;
        mole_next[next_idx] = 1'b1;
    end

`ifdef WAM_SPEEDUP_EN
    localparam int SPAN = (WIN_INIT > WIN_MIN) ? WIN_INIT - WIN_MIN : 0;
    logic [31:0] reduce;
    always_comb begin
        reduce = 32'(level_q) * 32'(WIN_STEP);
        if (reduce >= 32'(SPAN)) window = WIN_W'(WIN_MIN);
        else                     window = WIN_W'(32'(WIN_INIT) - reduce);
    end
`else
    assign window = WIN_W'(WIN_INIT);
`endif

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        lfsr_d       = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);
        mole_d       = mole_q;
        score_d      = score_q;
        level_d      = level_q;
        misses_d     = misses_q;
        hit_cnt_d    = hit_cnt_q;
        prev_idx_d   = prev_idx_q;
        hit_pulse_d  = 1'b0;
        miss_pulse_d = 1'b0;

        case (state_q)
            S_IDLE, S_OVER: begin
                mole_d = '0;
                if (start_i) begin
                    score_d    = '0;
                    misses_d   = '0;
                    level_d    = '0;
                    hit_cnt_d  = '0;
                    prev_idx_d = '0;
                    timer_d    = WIN_W'(GAP_CYCLES - 1);
                    state_d    = S_GAP;
                end
            end
            S_GAP: begin
                timer_d = timer_q - 1'b1;
                if (expired) begin
                    prev_idx_d = next_idx;
                    mole_d     = mole_next;
                    timer_d    = window - 1'b1;
                    state_d    = S_UP;
                end
            end
            S_UP: begin
                timer_d = timer_q - 1'b1;
                if (hit) begin
                    hit_pulse_d = 1'b1;
                    if (score_q != '1) score_d = score_q + 1'b1;
                    if (hit_cnt_q + 1'b1 == HC_W'(LEVEL_UP)) begin
                        hit_cnt_d = '0;
                        if (level_q != 4'hF) level_d = level_q + 1'b1;
                    end else begin
                        hit_cnt_d = hit_cnt_q + 1'b1;
                    end
                    mole_d  = '0;
                    timer_d = WIN_W'(GAP_CYCLES - 1);
                    state_d = S_GAP;
                end else if (wrong || expired) begin
                    miss_pulse_d = 1'b1;
                    misses_d     = misses_q + 1'b1;
                    mole_d       = '0;
                    if (misses_q + 1'b1 == 4'(MAX_MISS)) begin
                        state_d = S_OVER;
                    end else begin
                        timer_d = WIN_W'(GAP_CYCLES - 1);
                        state_d = S_GAP;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            timer_q      <= '0;
            lfsr_q       <= LFSR_SEED;
            btn_meta_q   <= '0;
            btn_s_q      <= '0;
            btn_d_q      <= '0;
            mole_q       <= '0;
            score_q      <= '0;
            level_q      <= '0;
            misses_q     <= '0;
            hit_cnt_q    <= '0;
            prev_idx_q   <= '0;
            hit_pulse_q  <= 1'b0;
            miss_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            lfsr_q       <= lfsr_d;
            btn_meta_q   <= btn_i;
            btn_s_q      <= btn_meta_q;
            btn_d_q      <= btn_s_q;
            mole_q       <= mole_d;
            score_q      <= score_d;
            level_q      <= level_d;
            misses_q     <= misses_d;
            hit_cnt_q    <= hit_cnt_d;
            prev_idx_q   <= prev_idx_d;
            hit_pulse_q  <= hit_pulse_d;
            miss_pulse_q <= miss_pulse_d;
        end
    end

    assign mole_o       = mole_q;
    assign score_o      = score_q;
    assign level_o      = level_q;
    assign misses_o     = misses_q;
    assign state_o      = state_q;
    assign game_over_o  = (state_q == S_OVER);
    assign hit_pulse_o  = hit_pulse_q;
    assign miss_pulse_o = miss_pulse_q;

endmodule

// File: tb/tb_whack_a_mole_core_n.sv
// Directed testbench for whack_a_mole_core_n with small timing parameters (N_MOLES=4).
module tb_whack_a_mole_core_n;

    localparam int N   = 4;
    localparam int GAP = 5;
`ifdef WAM_SPEEDUP_EN
    localparam int W_L1 = 16;
    localparam int W_L3 = 8;
`else
    localparam int W_L1 = 20;
    localparam int W_L3 = 20;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] btn = '0;
    logic [N-1:0] mole;
    logic [7:0]   score;
    logic [3:0]   level, misses;
    logic [1:0]   state;
    logic         game_over, hit_pulse, miss_pulse;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    whack_a_mole_core_n #(
        .N_MOLES(N), .SCORE_W(8), .WIN_W(16), .WIN_INIT(20), .WIN_STEP(4), .WIN_MIN(8),
        .GAP_CYCLES(GAP), .LEVEL_UP(2), .MAX_MISS(3), .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .btn_i(btn),
        .mole_o(mole), .score_o(score), .level_o(level), .misses_o(misses),
        .state_o(state), .game_over_o(game_over),
        .hit_pulse_o(hit_pulse), .miss_pulse_o(miss_pulse)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        btn   = '0;
        #3;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic start_game();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_up();
        for (int i = 0; i < 60 && state != 2'd2; i++) tick();
        n_cmp++;
        if (state !== 2'd2) begin
            n_bad++;
            $display("FAIL wait_up: state=%0d, expected 2 within 60 cycles", state);
        end
    endtask

    task automatic hit_now(input int delay);
        repeat (delay) tick();
        btn = mole;
        for (int i = 0; i < 6 && !hit_pulse; i++) tick();
        n_cmp++;
        if (hit_pulse !== 1'b1) begin
            n_bad++;
            $display("FAIL hit_now: hit_pulse=%0b, expected 1 within 6 cycles", hit_pulse);
        end
        btn = '0;
    endtask

    task automatic measure_up(input string name, input int exp_len);
        int up_n;
        int hits;
        up_n = 0;
        hits = 0;
        while (state == 2'd2 && up_n < 60) begin
            tick();
            up_n++;
            if (hit_pulse) hits++;
        end
        n_cmp++;
        if (up_n !== exp_len) begin
            n_bad++;
            $display("FAIL %s_len: UP lasted %0d, expected %0d", name, up_n, exp_len);
        end
        n_cmp++;
        if (hits !== 0 || miss_pulse !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_end: hits=%0d miss_pulse=%0b, expected 0 and 1", name, hits, miss_pulse);
        end
    endtask

    task automatic test_reset_and_start();
        do_reset();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({state, mole, score, level, misses, game_over, hit_pulse, miss_pulse} !== '0) begin
            n_bad++;
            $display("FAIL reset_vals: state=%0d mole=%0h score=%0d level=%0d misses=%0d, expected all 0",
                     state, mole, score, level, misses);
        end
        tick();
        rst_n = 1'b1;
        tick();
        start_game();
        begin
            int gap_n;
            gap_n = 0;
            while (state == 2'd1 && gap_n < 50) begin
                gap_n++;
                tick();
            end
            n_cmp++;
            if (gap_n !== GAP) begin
                n_bad++;
                $display("FAIL gap_len: GAP lasted %0d, expected %0d", gap_n, GAP);
            end
        end
        n_cmp++;
        if (state !== 2'd2 || $countones(mole) !== 1 || score !== 8'd0) begin
            n_bad++;
            $display("FAIL first_up: state=%0d mole=%0h score=%0d, expected 2, one-hot, 0", state, mole, score);
        end
    endtask

    task automatic test_hit_and_hold();
        do_reset();
        start_game();
        wait_up();
        repeat (3) tick();
        btn = mole;
        for (int i = 0; i < 6 && !hit_pulse; i++) tick();
        n_cmp++;
        if (hit_pulse !== 1'b1 || score !== 8'd1 || mole !== '0 || state !== 2'd1) begin
            n_bad++;
            $display("FAIL hit_basic: pulse=%0b score=%0d mole=%0h state=%0d, expected 1 1 0 1",
                     hit_pulse, score, mole, state);
        end
        tick();
        n_cmp++;
        if (hit_pulse !== 1'b0) begin
            n_bad++;
            $display("FAIL hit_pulse_width: pulse=%0b one cycle later, expected 0", hit_pulse);
        end
        wait_up();
        measure_up("hold", 20);
        n_cmp++;
        if (score !== 8'd1 || misses !== 4'd1) begin
            n_bad++;
            $display("FAIL hold_counts: score=%0d misses=%0d, expected 1 1", score, misses);
        end
        btn = '0;
    endtask

    task automatic test_levels();
        do_reset();
        start_game();
        wait_up();
        hit_now(1);
        wait_up();
        hit_now(1);
        n_cmp++;
        if (level !== 4'd1 || score !== 8'd2) begin
            n_bad++;
            $display("FAIL level1: level=%0d score=%0d, expected 1 2", level, score);
        end
        wait_up();
        measure_up("win_l1", W_L1);
        for (int k = 0; k < 4; k++) begin
            wait_up();
            hit_now(1);
        end
        n_cmp++;
        if (level !== 4'd3 || score !== 8'd6 || misses !== 4'd1) begin
            n_bad++;
            $display("FAIL level3: level=%0d score=%0d misses=%0d, expected 3 6 1", level, score, misses);
        end
        wait_up();
        measure_up("win_l3", W_L3);
    endtask

    task automatic test_game_over();
        int mp;
        do_reset();
        start_game();
        wait_up();
        hit_now(1);
        mp = 0;
        for (int i = 0; i < 120 && state != 2'd3; i++) begin
            tick();
            if (miss_pulse) mp++;
        end
        n_cmp++;
        if (mp !== 3 || misses !== 4'd3 || state !== 2'd3 || game_over !== 1'b1) begin
            n_bad++;
            $display("FAIL over_entry: pulses=%0d misses=%0d state=%0d go=%0b, expected 3 3 3 1",
                     mp, misses, state, game_over);
        end
        repeat (4) tick();
        n_cmp++;
        if (state !== 2'd3 || score !== 8'd1 || mole !== '0 || misses !== 4'd3) begin
            n_bad++;
            $display("FAIL over_hold: state=%0d score=%0d mole=%0h misses=%0d, expected 3 1 0 3",
                     state, score, mole, misses);
        end
        start_game();
        n_cmp++;
        if (score !== 8'd0 || misses !== 4'd0 || state !== 2'd1 || game_over !== 1'b0) begin
            n_bad++;
            $display("FAIL restart: score=%0d misses=%0d state=%0d go=%0b, expected 0 0 1 0",
                     score, misses, state, game_over);
        end
    endtask

    task automatic test_priority();
        logic [N-1:0] wrong;
        do_reset();
        start_game();
        wait_up();
        wrong = {mole[N-2:0], mole[N-1]};
        btn = mole | wrong;
        for (int i = 0; i < 6 && !hit_pulse && !miss_pulse; i++) tick();
        n_cmp++;
        if (hit_pulse !== 1'b1 || miss_pulse !== 1'b0 || score !== 8'd1 || misses !== 4'd0) begin
            n_bad++;
            $display("FAIL both_press: hit=%0b miss=%0b score=%0d misses=%0d, expected 1 0 1 0",
                     hit_pulse, miss_pulse, score, misses);
        end
        btn = '0;
        wait_up();
        btn = {mole[N-2:0], mole[N-1]};
        for (int i = 0; i < 6 && !hit_pulse && !miss_pulse; i++) tick();
        n_cmp++;
        if (miss_pulse !== 1'b1 || hit_pulse !== 1'b0 || misses !== 4'd1 || score !== 8'd1 || state !== 2'd1) begin
            n_bad++;
            $display("FAIL wrong_press: miss=%0b hit=%0b misses=%0d score=%0d state=%0d, expected 1 0 1 1 1",
                     miss_pulse, hit_pulse, misses, score, state);
        end
        btn = '0;
        wait_up();
        repeat (17) tick();
        btn = mole;
        tick();
        tick();
        n_cmp++;
        if (state !== 2'd2 || hit_pulse !== 1'b0 || miss_pulse !== 1'b0) begin
            n_bad++;
            $display("FAIL pre_expiry: state=%0d hit=%0b miss=%0b, expected 2 0 0", state, hit_pulse, miss_pulse);
        end
        tick();
        n_cmp++;
        if (hit_pulse !== 1'b1 || miss_pulse !== 1'b0 || score !== 8'd2 || misses !== 4'd1) begin
            n_bad++;
            $display("FAIL expiry_hit: hit=%0b miss=%0b score=%0d misses=%0d, expected 1 0 2 1",
                     hit_pulse, miss_pulse, score, misses);
        end
        btn = '0;
    endtask

    task automatic test_async_reset_and_dedup();
        int prev_idx, idx;
        do_reset();
        start_game();
        wait_up();
        hit_now(0);
        wait_up();
        rst_n = 1'b0;
        #2;
        n_cmp++;
        if (mole !== '0 || score !== 8'd0 || state !== 2'd0 || misses !== 4'd0) begin
            n_bad++;
            $display("FAIL async_reset: mole=%0h score=%0d state=%0d misses=%0d, expected all 0",
                     mole, score, state, misses);
        end
        #1;
        rst_n = 1'b1;
        tick();
        start_game();
        prev_idx = 0;
        for (int m = 0; m < 200; m++) begin
            wait_up();
            idx = 0;
            for (int b = 0; b < N; b++) if (mole[b]) idx = b;
            n_cmp++;
            if ($countones(mole) !== 1 || idx == prev_idx) begin
                n_bad++;
                $display("FAIL dedup[%0d]: mole=%0h idx=%0d prev=%0d, expected one-hot and idx != prev",
                         m, mole, idx, prev_idx);
            end
            prev_idx = idx;
            hit_now(0);
        end
        n_cmp++;
        if (score !== 8'd200 || level !== 4'd15) begin
            n_bad++;
            $display("FAIL long_run: score=%0d level=%0d, expected 200 15", score, level);
        end
    endtask

    initial begin
        test_reset_and_start();
        test_hit_and_hold();
        test_levels();
        test_game_over();
        test_priority();
        test_async_reset_and_dedup();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
